// File: rtl/mcycle_pkg.sv
// Shared types and constants for the MCycle arbiter/sequencer.
// Holds the FSM state encoding, op codes, default widths and a grant decode helper.
package mcycle_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultCntw  = 16;

  localparam logic MC_OP_MUL = 1'b0;
  localparam logic MC_OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitDone,
    StResp
  } mc_state_e;

  // Index of the granted requester in a one-hot 2-bit grant vector.
  function automatic logic grant_idx(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, and on a tie
// the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mcycle_arbiter.sv
// Arbitrates two requesters onto a single multi-cycle mul/div unit, sequences the
// Start/Busy handshake and returns the captured result with its launch-to-capture latency.
module mcycle_arbiter
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNTW  = DefaultCntw
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic [1:0]         ReqValid,
  input  logic [1:0]         ReqOp,
  input  logic [2*WIDTH-1:0] ReqOperand1,
  input  logic [2*WIDTH-1:0] ReqOperand2,
  output logic [1:0]         ReqReady,
  output logic [1:0]         RespValid,
  input  logic [1:0]         RespReady,
  output logic [WIDTH-1:0]   RespResult,
  output logic [CNTW-1:0]    RespCycles,
  output logic               MC_Start,
  output logic               MC_Op,
  output logic [WIDTH-1:0]   MC_Operand1,
  output logic [WIDTH-1:0]   MC_Operand2,
  input  logic [WIDTH-1:0]   MC_Result,
  input  logic               MC_Busy
);

  mc_state_e        state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] opnd1_q, opnd1_d;
  logic [WIDTH-1:0] opnd2_q, opnd2_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNTW-1:0]  cycles_q, cycles_d;
  // Keeps ReqReady low until the first clock edge after reset release.
  logic             armed_q, armed_d;

  logic [1:0]       gnt;
  logic             win;
  logic [CNTW-1:0]  cnt_inc;

  rr_arb2 u_rr_arb2 (
    .req_i  (ReqValid),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign win     = grant_idx(gnt);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNTW'(1);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    op_d      = op_q;
    opnd1_d   = opnd1_q;
    opnd2_d   = opnd2_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    cycles_d  = cycles_q;
    armed_d   = 1'b1;
    ReqReady  = 2'b00;
    RespValid = 2'b00;
    MC_Start  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (armed_q) begin
          ReqReady = gnt;
          // gnt is a subset of ReqValid, so any grant is a completed handshake.
          if (|gnt) begin
            owner_d = win;
            op_d    = ReqOp[win];
            opnd1_d = win ? ReqOperand1[WIDTH +: WIDTH] : ReqOperand1[0 +: WIDTH];
            opnd2_d = win ? ReqOperand2[WIDTH +: WIDTH] : ReqOperand2[0 +: WIDTH];
            cnt_d   = '0;
            state_d = StLaunch;
          end
        end
      end

      StLaunch: begin
        MC_Start = 1'b1;
        cnt_d    = cnt_inc;
        if (MC_Busy) begin
          state_d = StWaitDone;
        end
      end

      StWaitDone: begin
        cnt_d = cnt_inc;
        if (!MC_Busy) begin
          result_d = MC_Result;
          cycles_d = cnt_inc;
          state_d  = StResp;
        end
      end

      StResp: begin
        RespValid = owner_q ? 2'b10 : 2'b01;
        if (RespReady[owner_q]) begin
          last_d  = owner_q;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      op_q     <= MC_OP_MUL;
      opnd1_q  <= '0;
      opnd2_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cycles_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      opnd1_q  <= opnd1_d;
      opnd2_q  <= opnd2_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
      armed_q  <= armed_d;
    end
  end

  assign RespResult  = result_q;
  assign RespCycles  = cycles_q;
  assign MC_Op       = op_q;
  assign MC_Operand1 = opnd1_q;
  assign MC_Operand2 = opnd2_q;

endmodule
